macc_seq: RTL and testbench

//  Sequences one matrix pass through the matrix_ctrl address generator and its memory.

---
 rtl/macc_pkg.sv | 12 +
 rtl/macc_fifo.sv | 53 +++++
 rtl/macc_seq.sv | 159 +++++++++++++++
 tb/tb_macc_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared types for the matrix-pass sequencer: FSM states and element tags.
`timescale 1ns/1ps
package macc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} macc_state_t;

  typedef struct packed {
    logic first;
    logic last;
  } macc_tag_t;

endpackage

// File: rtl/macc_fifo.sv
// Small synchronous FIFO buffering tagged read data ahead of the MAC.
`timescale 1ns/1ps
module macc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                         CLK,
  input  logic                         RST_L,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/macc_seq.sv
// Matrix pass sequencer: host load, credit-paced row-major readback, tagged
// stream to the MAC, then flush and done.
`timescale 1ns/1ps
module macc_seq
  import macc_pkg::*;
#(
  parameter int ADDR_MSB   = 11,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_L,
  input  logic              start,
  input  logic [ADDR_MSB:0] cfg_max_row,
  input  logic [ADDR_MSB:0] cfg_max_col,
  output logic              busy,
  output logic              done,
  input  logic              host_wr_vld,
  output logic              host_wr_rdy,
  output logic [ADDR_MSB:0] max_row_cnt,
  output logic [ADDR_MSB:0] max_col_cnt,
  output logic              mat_we,
  output logic              mat_re,
  input  logic [DATA_W-1:0] mat_rdata,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);
  localparam int CW     = ADDR_MSB + 1;
  localparam int CRED_W = $clog2(FIFO_DEPTH+1);
  localparam int FW     = DATA_W + 2;

  macc_state_t state_q, state_d;
  logic [CW-1:0] max_row_q, max_row_d, max_col_q, max_col_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [RD_LAT-1:0]     vld_pipe_q;
  macc_tag_t [RD_LAT-1:0] tag_pipe_q;
  macc_tag_t   issue_tag, head_tag;
  logic        at_end, step;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [CRED_W-1:0] fifo_cnt, in_flight, credits;
  logic [FW-1:0]     fifo_rdata;

  assign at_end          = (row_q == max_row_q) && (col_q == max_col_q);
  assign issue_tag.first = (col_q == '0);
  assign issue_tag.last  = (col_q == max_col_q);
  assign max_row_cnt     = max_row_q;
  assign max_col_cnt     = max_col_q;

  // Free slots = buffer room not already claimed by reads still in the memory pipe.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CRED_W'(vld_pipe_q[i]);
    credits = CRED_W'(FIFO_DEPTH) - fifo_cnt - in_flight;
  end

  always_comb begin
    state_d     = state_q;
    max_row_d   = max_row_q;
    max_col_d   = max_col_q;
    row_d       = row_q;
    col_d       = col_q;
    busy        = 1'b0;
    done        = 1'b0;
    host_wr_rdy = 1'b0;
    mat_we      = 1'b0;
    mat_re      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          max_row_d = cfg_max_row;
          max_col_d = cfg_max_col;
          row_d     = '0;
          col_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        host_wr_rdy = 1'b1;
        mat_we      = host_wr_vld;
        if (mat_we && at_end) state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        mat_re = (credits != '0) && !fifo_full;
        if (mat_re && at_end) state_d = FLUSH;
      end
      FLUSH: begin
        if ((vld_pipe_q == '0) && fifo_empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Mirror of the address generator's row/col counter.
    step = mat_we | mat_re;
    if (step) begin
      if (col_q == max_col_q) begin
        col_d = '0;
        row_d = (row_q == max_row_q) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q    <= IDLE;
      max_row_q  <= '0;
      max_col_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      max_row_q     <= max_row_d;
      max_col_q     <= max_col_d;
      row_q         <= row_d;
      col_q         <= col_d;
      vld_pipe_q[0] <= mat_re;
      tag_pipe_q[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign fifo_pop = ~fifo_empty & out_rdy;

  macc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .CLK   (CLK),
    .RST_L (RST_L),
    .push  (vld_pipe_q[RD_LAT-1]),
    .pop   (fifo_pop),
    .wdata ({tag_pipe_q[RD_LAT-1], mat_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign head_tag  = macc_tag_t'(fifo_rdata[DATA_W +: 2]);
  assign out_vld   = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign out_first = ~fifo_empty & head_tag.first;
  assign out_last  = ~fifo_empty & head_tag.last;

endmodule

// File: tb/tb_macc_seq.sv
// Bench for macc_seq: models the address-generated memory and checks each pass
// against row-major order computed from R and C.
`timescale 1ns/1ps
module tb_macc_seq;
  localparam int AW = 12, DW = 16, RD_LAT = 2, DEPTH = 4;

  logic CLK = 1'b0, RST_L = 1'b0, start = 1'b0;
  logic [AW-1:0] cfg_max_row = '0, cfg_max_col = '0;
  logic busy, done, host_wr_vld = 1'b0, host_wr_rdy;
  logic [AW-1:0] max_row_cnt, max_col_cnt;
  logic mat_we, mat_re, out_vld, out_rdy = 1'b0, out_first, out_last;
  logic [DW-1:0] mat_rdata, out_data, host_wdata = '0;

  always #5 CLK = ~CLK;

  macc_seq #(.ADDR_MSB(AW-1), .DATA_W(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_L(RST_L), .start(start), .cfg_max_row(cfg_max_row),
    .cfg_max_col(cfg_max_col), .busy(busy), .done(done), .host_wr_vld(host_wr_vld),
    .host_wr_rdy(host_wr_rdy), .max_row_cnt(max_row_cnt), .max_col_cnt(max_col_cnt),
    .mat_we(mat_we), .mat_re(mat_re), .mat_rdata(mat_rdata), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_first(out_first), .out_last(out_last)
  );

  // Memory behind the address generator: sequential write/read addresses, RD_LAT read delay.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rpipe [RD_LAT];
  int wr_idx, rd_idx;
  assign mat_rdata = rpipe[RD_LAT-1];
  always @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      wr_idx <= 0; rd_idx <= 0;
      for (int i = 0; i < RD_LAT; i++) rpipe[i] <= '0;
    end else begin
      if (start && !busy) begin wr_idx <= 0; rd_idx <= 0; end
      if (mat_we) begin mem[wr_idx % 256] <= host_wdata; wr_idx <= wr_idx + 1; end
      if (mat_re) rd_idx <= rd_idx + 1;
      rpipe[0] <= mat_re ? mem[rd_idx % 256] : 16'hDEAD;
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
  end

  // MAC-side ready: 0 = always ready, 1 = random, 2 = stalled.
  int rdy_mode = 0;
  always @(negedge CLK) begin
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom % 2);
      default: out_rdy = 1'b0;
    endcase
  end

  // Event recorder (cumulative; each pass works on differences).
  int cyc = 0, we_n = 0, re_n = 0, beat_n = 0, done_n = 0, ov_n = 0;
  int we_cyc [4096];
  int re_cyc [4096];
  int b_cyc  [4096];
  int d_cyc  [256];
  logic [DW+1:0] b_val [4096];
  always @(posedge CLK) begin
    if (mat_we) begin we_cyc[we_n % 4096] = cyc; we_n++; end
    if (mat_re) begin re_cyc[re_n % 4096] = cyc; re_n++; end
    if (mat_we && mat_re) ov_n++;
    if (out_vld && out_rdy) begin
      b_val[beat_n % 4096] = {out_data, out_first, out_last};
      b_cyc[beat_n % 4096] = cyc;
      beat_n++;
    end
    if (done) begin d_cyc[done_n % 256] = cyc; done_n++; end
    cyc++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [DW-1:0] pdata [64];

  task automatic start_and_load(input int r, input int c, input int gap, output int loaded);
    int k, it, n;
    logic v;
    n = (r + 1) * (c + 1);
    for (int i = 0; i < 64; i++) pdata[i] = DW'($urandom);
    @(negedge CLK);
    cfg_max_row = AW'(r); cfg_max_col = AW'(c); start = 1'b1;
    k = 0; it = 0;
    while (k < n && it < 400) begin
      @(negedge CLK);
      start = 1'b0;
      cfg_max_row = AW'($urandom); cfg_max_col = AW'($urandom);
      case (gap)
        0:       v = 1'b1;
        1:       v = (it % 2 == 0);
        default: v = 1'($urandom % 2);
      endcase
      host_wr_vld = v; host_wdata = pdata[k];
      if (v && host_wr_rdy) k++;
      it++;
    end
    @(negedge CLK);
    host_wr_vld = 1'b0;
    loaded = k;
  endtask

  task automatic run_pass(input int r, input int c, input int gap, input int rm,
                          input int poke, input int exp_n);
    int we0, re0, b0, d0, ov0, loaded, it;
    logic f, l;
    we0 = we_n; re0 = re_n; b0 = beat_n; d0 = done_n; ov0 = ov_n;
    rdy_mode = rm;
    start_and_load(r, c, gap, loaded);
    chk("load_accepted", 64'(loaded), 64'(exp_n));
    if (poke != 0) begin
      cfg_max_row = AW'(r + 1); cfg_max_col = AW'(c + 1); start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("poke_counts", 64'({max_row_cnt, max_col_cnt}), 64'({AW'(r), AW'(c)}));
    end
    if (rm == 2) begin
      repeat (20) @(negedge CLK);
      chk("stall_re_count", 64'(re_n - re0), 64'(DEPTH));
      chk("stall_head", 64'({out_vld, out_data, out_first}), 64'({1'b1, pdata[0], 1'b1}));
      rdy_mode = 0;
    end
    it = 0;
    while (done_n == d0 && it < 1000) begin @(negedge CLK); it++; end
    repeat (4) @(negedge CLK);
    chk("done_count", 64'(done_n - d0), 64'd1);
    chk("we_count", 64'(we_n - we0), 64'(exp_n));
    chk("re_count", 64'(re_n - re0), 64'(exp_n));
    chk("beat_count", 64'(beat_n - b0), 64'(exp_n));
    chk("we_re_overlap", 64'(ov_n - ov0), 64'd0);
    if (we_n - we0 >= exp_n && re_n > re0)
      chk("run_after_load", 64'(re_cyc[re0 % 4096] - we_cyc[(we0 + exp_n - 1) % 4096]), 64'd1);
    if (beat_n - b0 >= exp_n && done_n > d0)
      chk("done_after_accept", 64'(d_cyc[d0 % 256] - b_cyc[(b0 + exp_n - 1) % 4096]), 64'd1);
    for (int i = 0; i < exp_n && b0 + i < beat_n; i++) begin
      f = ((i % (c + 1)) == 0);
      l = ((i % (c + 1)) == c);
      chk($sformatf("beat[%0d]", i), 64'(b_val[(b0 + i) % 4096]), 64'({pdata[i], f, l}));
    end
    chk("idle_after", 64'({busy, out_vld}), 64'd0);
    chk("held_counts", 64'({max_row_cnt, max_col_cnt}), 64'({AW'(r), AW'(c)}));
  endtask

  typedef struct {
    int r; int c; int gap; int rm; int poke; int exp_n;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int loaded, rr, cc;
    tbl[0] = '{1, 2, 0, 0, 0, 6};
    tbl[1] = '{1, 2, 1, 0, 0, 6};
    tbl[2] = '{3, 3, 0, 2, 0, 16};
    tbl[3] = '{0, 0, 0, 0, 0, 1};
    tbl[4] = '{0, 0, 1, 1, 0, 1};
    tbl[5] = '{2, 1, 2, 1, 1, 6};
    tbl[6] = '{3, 2, 2, 1, 0, 12};

    #1;
    chk("reset_ctrl", 64'({busy, done, host_wr_rdy, mat_we, mat_re, out_vld, out_first, out_last}), 64'd0);
    chk("reset_data", 64'({out_data, max_row_cnt, max_col_cnt}), 64'd0);
    repeat (3) @(negedge CLK);
    RST_L = 1'b1;

    foreach (tbl[i])
      run_pass(tbl[i].r, tbl[i].c, tbl[i].gap, tbl[i].rm, tbl[i].poke, tbl[i].exp_n);

    // Reset in the middle of RUN, then a fresh pass must start from element (0,0).
    rdy_mode = 1;
    start_and_load(3, 3, 0, loaded);
    repeat (3) @(negedge CLK);
    RST_L = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({busy, done, host_wr_rdy, mat_we, mat_re, out_vld}), 64'd0);
    chk("midreset_counts", 64'({max_row_cnt, max_col_cnt, out_data}), 64'd0);
    @(negedge CLK);
    RST_L = 1'b1;
    run_pass(0, 1, 0, 0, 0, 2);

    for (int p = 0; p < 6; p++) begin
      rr = int'($urandom_range(0, 3));
      cc = int'($urandom_range(0, 3));
      run_pass(rr, cc, 2, 1, 0, (rr + 1) * (cc + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
